aes_ctr_stage: RTL and testbench

- Sequential CTR-mode front/back end for the combinational AES-128 encryption core.
- Holds key and counter block, drives the core's data and key inputs, and captures the core's ciphertext as keystream.
- XORs the keystream with each accepted 128-bit input block and presents the result on a valid/ready output.
- Sits directly upstream of the core (feeds its data input) and directly downstream of it (consumes its output).

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_ctr_stage.sv | 196 +++++++++++++++++++
 tb/tb_aes_ctr_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared types and helpers for the AES CTR-mode stage.
//   - AES_BLK_W / AES_KEY_W : block and key widths (128 bits each)
//   - aes_blk_t / aes_key_t : 128-bit block and key types
//   - ctr_state_e           : stage FSM states
//   - ctr_mask / ctr_inc / ctr_low_ones : counter helpers that treat the low
//     ctr_w bits of a block as a counter and the upper bits as a fixed nonce.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;
  typedef logic [AES_KEY_W-1:0] aes_key_t;

  typedef enum logic [1:0] {
    UNKEYED = 2'd0,
    READY   = 2'd1,
    WAIT    = 2'd2,
    OUT     = 2'd3
  } ctr_state_e;

  // Ones in the low ctr_w bits. For ctr_w == 128 the shift yields 0 and the
  // subtraction wraps to all ones, which is exactly the full-width mask.
  function automatic aes_blk_t ctr_mask(input int ctr_w);
    return (aes_blk_t'(1) << ctr_w) - aes_blk_t'(1);
  endfunction

  // Increment the low ctr_w bits modulo 2^ctr_w; the carry out of the counter
  // field is masked off so the nonce bits never change.
  function automatic aes_blk_t ctr_inc(input aes_blk_t blk, input int ctr_w);
    aes_blk_t mask;
    mask = ctr_mask(ctr_w);
    return (blk & ~mask) | ((blk + aes_blk_t'(1)) & mask);
  endfunction

  // True when the next increment wraps the counter field back to zero.
  function automatic logic ctr_low_ones(input aes_blk_t blk, input int ctr_w);
    aes_blk_t mask;
    mask = ctr_mask(ctr_w);
    return (blk & mask) == mask;
  endfunction

endpackage

// File: rtl/aes_ctr_stage.sv
// ---------------------------------------------------------------------------
// aes_ctr_stage
//   CTR-mode wrapper around an external AES-128 encryption core. Holds the key
//   and counter block, drives them into the core, captures the core output as
//   keystream and XORs it with each accepted input block. One block is in
//   flight at a time; the counter advances when the result is taken.
//
// Parameters
//   CTR_W    : low counter bits incremented per block (1..128)
//   CORE_LAT : core latency in clocks (0..15), 0 for a combinational core
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   load, key_in, iv_in       : load key and initial counter block
//   in_valid/in_ready/in_data : input block handshake
//   out_valid/out_ready/out_data : result handshake (in_data ^ keystream)
//   core_datain, core_key     : to the AES core (counter and key registers)
//   core_dataout              : keystream from the AES core
//   ctr_wrap                  : sticky, counter field wrapped since load
//   keyed                     : a key/IV has been loaded since reset
//   blk_count                 : saturating count of output handshakes,
//                               present only when AES_CTR_STATS_EN is defined
// ---------------------------------------------------------------------------
module aes_ctr_stage
  import aes_pkg::*;
#(
  parameter int CTR_W    = 32,
  parameter int CORE_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic [AES_BLK_W-1:0] iv_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic [AES_BLK_W-1:0] core_datain,
  output logic [AES_KEY_W-1:0] core_key,
  input  logic [AES_BLK_W-1:0] core_dataout,
  output logic                 ctr_wrap,
  output logic                 keyed
`ifdef AES_CTR_STATS_EN
  ,
  output logic [31:0]          blk_count
`endif
);

  localparam int WAIT_W = 4;

  ctr_state_e        state_q, state_d;
  aes_key_t          key_q, key_d;
  aes_blk_t          ctr_q, ctr_d;
  aes_blk_t          data_q, data_d;
  aes_blk_t          out_data_q, out_data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ctr_wrap_q, ctr_wrap_d;
  logic              keyed_q, keyed_d;
`ifdef AES_CTR_STATS_EN
  logic [31:0]       blk_count_q, blk_count_d;
`endif

  // load overrides every handshake, so the events below are all gated by it.
  logic in_fire;
  logic out_fire;
  logic core_done;

  assign in_fire   = (state_q == READY) && in_valid  && !load;
  assign out_fire  = (state_q == OUT)   && out_ready && !load;
  assign core_done = (state_q == WAIT)  && (wait_q == '0) && !load;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the data registers are reset too, because out_data, core_datain
    // and core_key must read as zero straight after reset.
    if (rst) begin
      state_q     <= UNKEYED;
      key_q       <= '0;
      ctr_q       <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      wait_q      <= '0;
      ctr_wrap_q  <= 1'b0;
      keyed_q     <= 1'b0;
`ifdef AES_CTR_STATS_EN
      blk_count_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      key_q       <= key_d;
      ctr_q       <= ctr_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      wait_q      <= wait_d;
      ctr_wrap_q  <= ctr_wrap_d;
      keyed_q     <= keyed_d;
`ifdef AES_CTR_STATS_EN
      blk_count_q <= blk_count_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d
    // unassigned and infers a latch.
    state_d = state_q;
    if (load) begin
      state_d = READY;
    end else begin
      unique case (state_q)
        UNKEYED: state_d = UNKEYED;
        READY:   if (in_valid)          state_d = WAIT;
        WAIT:    if (wait_q == '0)      state_d = OUT;
        OUT:     if (out_ready)         state_d = READY;
        default: state_d = UNKEYED;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    key_d      = key_q;
    ctr_d      = ctr_q;
    data_d     = data_q;
    out_data_d = out_data_q;
    wait_d     = wait_q;
    ctr_wrap_d = ctr_wrap_q;
    keyed_d    = keyed_q;

    if (load) begin
      key_d      = key_in;
      ctr_d      = iv_in;
      ctr_wrap_d = 1'b0;
      keyed_d    = 1'b1;
    end

    if (in_fire) begin
      data_d = in_data;
      wait_d = WAIT_W'(CORE_LAT);
    end else if (state_q == WAIT && wait_q != '0) begin
      wait_d = wait_q - WAIT_W'(1);
    end

    // The counter is held from accept to output handshake, so the core
    // output at this edge is the keystream for the block in data_q.
    if (core_done) begin
      out_data_d = data_q ^ core_dataout;
    end

    if (out_fire) begin
      ctr_d = ctr_inc(ctr_q, CTR_W);
      if (ctr_low_ones(ctr_q, CTR_W)) begin
        ctr_wrap_d = 1'b1;
      end
    end
  end

`ifdef AES_CTR_STATS_EN
  always_comb begin
    blk_count_d = blk_count_q;
    if (load) begin
      blk_count_d = '0;
    end else if (out_fire && blk_count_q != 32'hFFFF_FFFF) begin
      blk_count_d = blk_count_q + 32'd1;
    end
  end

  assign blk_count = blk_count_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == READY);
    out_valid = (state_q == OUT);
  end

  assign out_data    = out_data_q;
  assign core_datain = ctr_q;
  assign core_key    = key_q;
  assign ctr_wrap    = ctr_wrap_q;
  assign keyed       = keyed_q;

endmodule

// File: tb/tb_aes_ctr_stage.sv
// ---------------------------------------------------------------------------
// tb_aes_ctr_stage
//   Self-checking bench for aes_ctr_stage. A behavioural AES-128 function
//   stands in for the combinational core, and a transaction-level model
//   (key, counter, wrap flag) predicts every result.
// ---------------------------------------------------------------------------
module tb_aes_ctr_stage;
  import aes_pkg::*;

  localparam int CTR_W    = 32;
  localparam int CORE_LAT = 0;

  logic     clk = 1'b0;
  logic     rst;
  logic     load;
  aes_key_t key_in;
  aes_blk_t iv_in;
  logic     in_valid;
  logic     in_ready;
  aes_blk_t in_data;
  logic     out_valid;
  logic     out_ready;
  aes_blk_t out_data;
  aes_blk_t core_datain;
  aes_key_t core_key;
  aes_blk_t core_dataout;
  logic     ctr_wrap;
  logic     keyed;
`ifdef AES_CTR_STATS_EN
  logic [31:0] blk_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  aes_key_t m_key;
  aes_blk_t m_ctr;
  aes_blk_t m_data;
  logic     m_wrap;

  always #5 clk = ~clk;

  aes_ctr_stage #(.CTR_W(CTR_W), .CORE_LAT(CORE_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .key_in       (key_in),
    .iv_in        (iv_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .core_datain  (core_datain),
    .core_key     (core_key),
    .core_dataout (core_dataout),
    .ctr_wrap     (ctr_wrap),
    .keyed        (keyed)
`ifdef AES_CTR_STATS_EN
    ,
    .blk_count    (blk_count)
`endif
  );

  // -------------------------------------------------------------------------
  // Behavioural AES-128 encryption (FIPS-197)
  // -------------------------------------------------------------------------
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_blk_t aes128(input aes_key_t key, input aes_blk_t pt);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    logic [7:0]  a0, a1, a2, a3;
    aes_blk_t    res;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sub(tmp[23:16]), sub(tmp[15:8]), sub(tmp[7:0]), sub(tmp[31:24])}
              ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row + 4 * c] = sub(s[row + 4 * ((c + row) % 4)]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  // Combinational core stand-in
  always_comb core_dataout = aes128(core_key, core_datain);

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic aes_blk_t rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model counter step: low 32 bits count, upper 96 bits are the nonce.
  task automatic model_advance();
    if (m_ctr[31:0] == 32'hffff_ffff) m_wrap = 1'b1;
    m_ctr = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
  endtask

  task automatic do_load(input aes_key_t k, input aes_blk_t iv);
    load = 1'b1; key_in = k; iv_in = iv;
    step();
    load = 1'b0; key_in = rand_blk(); iv_in = rand_blk();
    m_key = k; m_ctr = iv; m_wrap = 1'b0;
    check("load_in_ready", in_ready, 1'b1);
    check("load_out_valid", out_valid, 1'b0);
    check("load_core_key", core_key, m_key);
    check("load_core_datain", core_datain, m_ctr);
    check("load_ctr_wrap", ctr_wrap, 1'b0);
    check("load_keyed", keyed, 1'b1);
  endtask

  // Present a block until it is taken; in_data is scrambled afterwards so a
  // late sample would corrupt the result.
  task automatic accept_block(input aes_blk_t d);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1; in_data = d;
    do begin
      rdy = in_ready;
      step();
      n++;
    end while (!rdy && n < 20);
    in_valid = 1'b0; in_data = rand_blk();
    if (!rdy) check("accept_timeout", 1'b0, 1'b1);
    m_data = d;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("out_latency", n, CORE_LAT + 1);
  endtask

  // Hold backpressure for 'hold' cycles, then take the result.
  task automatic finish_out(input int hold);
    aes_blk_t exp;
    exp = m_data ^ aes128(m_key, m_ctr);
    check("out_valid", out_valid, 1'b1);
    check("out_data", out_data, exp);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = rand_blk();
      step();
      in_valid = 1'b0;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, exp);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_ctr", core_datain, m_ctr);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    model_advance();
    check("post_out_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    check("post_ctr", core_datain, m_ctr);
    check("post_ctr_wrap", ctr_wrap, m_wrap);
  endtask

  task automatic check_reset_state();
    check("rst_out_data", out_data, '0);
    check("rst_core_datain", core_datain, '0);
    check("rst_core_key", core_key, '0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ctr_wrap", ctr_wrap, 1'b0);
    check("rst_keyed", keyed, 1'b0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aes_blk_t iv;
    rst = 1'b1; load = 1'b0; key_in = '0; iv_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_key = '0; m_ctr = '0; m_data = '0; m_wrap = 1'b0;

    // Reset state
    step(); step();
    check_reset_state();
    rst = 1'b0;

    // Input ignored while unkeyed
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = rand_blk();
      step();
    end
    in_valid = 1'b0;
    check("unkeyed_in_ready", in_ready, 1'b0);
    check("unkeyed_out_valid", out_valid, 1'b0);
    check("unkeyed_keyed", keyed, 1'b0);

    // FIPS-197 vector and counter step
    do_load(128'h000102030405060708090a0b0c0d0e0f,
            128'h00112233445566778899aabbccddeeff);
    accept_block('0);
    wait_out();
    check("fips_out", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    finish_out(0);
    check("ctr_step", core_datain, 128'h00112233445566778899aabbccddef00);
    check("ctr_step_wrap", ctr_wrap, 1'b0);

    // Backpressure for 10 cycles
    accept_block(rand_blk());
    wait_out();
    finish_out(10);

    // Counter wrap: sticky across a further block, cleared by load
    iv = rand_blk();
    iv[31:0] = 32'hffff_ffff;
    do_load(rand_blk(), iv);
    accept_block(rand_blk());
    wait_out();
    finish_out(1);
    check("wrap_low", core_datain[31:0], 32'h0);
    check("wrap_upper", core_datain[127:32], iv[127:32]);
    check("wrap_flag", ctr_wrap, 1'b1);
    accept_block(rand_blk());
    wait_out();
    finish_out(0);
    check("wrap_sticky", ctr_wrap, 1'b1);
    do_load(rand_blk(), rand_blk());

    // Abort during WAIT
    accept_block(rand_blk());
    do_load(rand_blk(), rand_blk());
    step();
    check("abort_wait_no_out", out_valid, 1'b0);
    check("abort_wait_ctr", core_datain, m_ctr);

    // Abort during OUT with a simultaneous output handshake
    accept_block(rand_blk());
    wait_out();
    out_ready = 1'b1;
    do_load(rand_blk(), rand_blk());
    out_ready = 1'b0;
    check("abort_out_ctr", core_datain, m_ctr);

    // load beats a simultaneous input handshake
    in_valid = 1'b1; in_data = rand_blk();
    do_load(rand_blk(), rand_blk());
    in_valid = 1'b0;
    step();
    check("load_vs_in_out_valid", out_valid, 1'b0);
    check("load_vs_in_in_ready", in_ready, 1'b1);

    // Block after aborts uses the freshly loaded counter
    accept_block(rand_blk());
    wait_out();
    finish_out(2);

    // Randomized traffic with occasional reloads near the wrap point
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        iv = rand_blk();
        if ($urandom_range(0, 1) == 1) iv[31:0] = 32'hffff_ffff - $urandom_range(0, 2);
        do_load(rand_blk(), iv);
      end
      repeat ($urandom_range(0, 2)) step();
      accept_block(rand_blk());
      wait_out();
      finish_out($urandom_range(0, 3));
    end

    // Reset in the middle of OUT
    accept_block(rand_blk());
    wait_out();
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    check_reset_state();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = rand_blk();
      step();
    end
    in_valid = 1'b0;
    check("post_rst_in_ready", in_ready, 1'b0);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_keyed", keyed, 1'b0);

    // Recovery after reset
    do_load(rand_blk(), rand_blk());
    accept_block(rand_blk());
    wait_out();
    finish_out(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
